// File: rtl/output_requant_fifo.sv
// -----------------------------------------------------------------------------
// output_requant_fifo
//
// Downstream stage of the convolution datapath. Each finished accumulator
// value is rescaled by an arithmetic right shift with round-half-up,
// saturated to OUT_WIDTH bits, and then buffered in a show-ahead FIFO.
// The FIFO is drained through a valid/ready handshake. Results that arrive
// while the FIFO is full and not being popped are dropped, and a sticky
// overflow flag records the drop.
//
// Optional feature (compile-time macro OUT_RELU_EN):
//   defined   : negative saturated results are forced to zero (fused ReLU)
//   undefined : the signed saturated result is passed through unchanged
//
// Ports:
//   clk            clock, rising edge
//   rst_in         synchronous reset, active-high, highest priority
//   shift          right-shift amount (0..ACC_WIDTH-1), static while running
//   in_valid       one-cycle strobe, accumulator result present
//   in_data        signed accumulator value
//   in_x/in_y/in_ch  coordinate of the result
//   out_valid      FIFO non-empty
//   out_ready      consumer accepts the head entry
//   out_data       signed requantized sample at FIFO head (0 when empty)
//   out_x/out_y/out_ch  head coordinate (0 when empty)
//   fifo_count     FIFO occupancy
//   overflow       sticky, a result was dropped
//   clear_overflow clears overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module output_requant_fifo #(
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int CH_WIDTH    = 6,
  parameter int SHIFT_WIDTH = 5,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                clk,
  input  logic                                rst_in,
  input  logic [SHIFT_WIDTH-1:0]              shift,
  input  logic                                in_valid,
  input  logic signed [ACC_WIDTH-1:0]         in_data,
  input  logic [X_WIDTH-1:0]                  in_x,
  input  logic [Y_WIDTH-1:0]                  in_y,
  input  logic [CH_WIDTH-1:0]                 in_ch,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_WIDTH-1:0]         out_data,
  output logic [X_WIDTH-1:0]                  out_x,
  output logic [Y_WIDTH-1:0]                  out_y,
  output logic [CH_WIDTH-1:0]                 out_ch,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
  output logic                                overflow,
  input  logic                                clear_overflow
);

  localparam int EXT_W = ACC_WIDTH + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // One extra bit of headroom so the rounding bias cannot wrap a value
  // close to the positive accumulator limit.
  function automatic logic signed [EXT_W-1:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] d,
    input logic [SHIFT_WIDTH-1:0]      s
  );
    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_bias;
    w_ext = {d[ACC_WIDTH-1], d};
    if (s == '0) begin
      return w_ext;
    end
    w_bias = EXT_W'(1) << (s - SHIFT_WIDTH'(1));
    return (w_ext + w_bias) >>> s;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(
    input logic signed [EXT_W-1:0] v
  );
    if (v > EXT_W'(OUT_MAX)) begin
      return OUT_MAX;
    end
    if (v < EXT_W'(OUT_MIN)) begin
      return OUT_MIN;
    end
    return v[OUT_WIDTH-1:0];
  endfunction

  logic signed [OUT_WIDTH-1:0] w_sat;
  logic signed [OUT_WIDTH-1:0] w_res;

  assign w_sat = saturate(round_shift(in_data, shift));

`ifdef OUT_RELU_EN
  assign w_res = w_sat[OUT_WIDTH-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif

  // ---- stage p1: requantized result register ----
  logic                        r_vld_p1;
  logic signed [OUT_WIDTH-1:0] r_data_p1;
  logic [X_WIDTH-1:0]          r_x_p1;
  logic [Y_WIDTH-1:0]          r_y_p1;
  logic [CH_WIDTH-1:0]         r_ch_p1;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_data_p1 <= w_res;
      r_x_p1    <= in_x;
      r_y_p1    <= in_y;
      r_ch_p1   <= in_ch;
    end
  end

  // ---- stage p2: show-ahead FIFO ----
  logic signed [OUT_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [X_WIDTH-1:0]          r_mem_x    [FIFO_DEPTH];
  logic [Y_WIDTH-1:0]          r_mem_y    [FIFO_DEPTH];
  logic [CH_WIDTH-1:0]         r_mem_ch   [FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_count;
  logic                        r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop  = out_valid && out_ready;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push may proceed.
  assign w_push = r_vld_p1 && (!w_full || w_pop);
  assign w_drop = r_vld_p1 && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= r_data_p1;
      r_mem_x[r_wr_ptr]    <= r_x_p1;
      r_mem_y[r_wr_ptr]    <= r_y_p1;
      r_mem_ch[r_wr_ptr]   <= r_ch_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Head fields are gated so the outputs read zero while the FIFO is empty.
  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_x      = out_valid ? r_mem_x[r_rd_ptr]    : '0;
  assign out_y      = out_valid ? r_mem_y[r_rd_ptr]    : '0;
  assign out_ch     = out_valid ? r_mem_ch[r_rd_ptr]   : '0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_output_requant_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for output_requant_fifo. Directed stimulus in one initial block;
// expected results are queued when driven and compared by a monitor when the
// DUT hands them out. Compile with +define+OUT_RELU_EN to exercise the ReLU
// variant.
// -----------------------------------------------------------------------------
module tb_output_requant_fifo;

  localparam int ACC_WIDTH   = 32;
  localparam int OUT_WIDTH   = 16;
  localparam int X_WIDTH     = 10;
  localparam int Y_WIDTH     = 10;
  localparam int CH_WIDTH    = 6;
  localparam int SHIFT_WIDTH = 5;
  localparam int FIFO_DEPTH  = 8;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

  logic                        clk;
  logic                        rst_in;
  logic [SHIFT_WIDTH-1:0]      shift;
  logic                        in_valid;
  logic signed [ACC_WIDTH-1:0] in_data;
  logic [X_WIDTH-1:0]          in_x;
  logic [Y_WIDTH-1:0]          in_y;
  logic [CH_WIDTH-1:0]         in_ch;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic [X_WIDTH-1:0]          out_x;
  logic [Y_WIDTH-1:0]          out_y;
  logic [CH_WIDTH-1:0]         out_ch;
  logic [CNT_W-1:0]            fifo_count;
  logic                        overflow;
  logic                        clear_overflow;

  output_requant_fifo #(
    .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .X_WIDTH(X_WIDTH),
    .Y_WIDTH(Y_WIDTH), .CH_WIDTH(CH_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_in(rst_in), .shift(shift), .in_valid(in_valid),
    .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_ch(out_ch), .fifo_count(fifo_count),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic signed [OUT_WIDTH-1:0] d;
    logic [X_WIDTH-1:0]          x;
    logic [Y_WIDTH-1:0]          y;
    logic [CH_WIDTH-1:0]         ch;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference requantizer on 64-bit integers.
  function automatic logic signed [OUT_WIDTH-1:0] model(input longint d, input int s);
    longint r;
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
    mn = -(longint'(1) <<< (OUT_WIDTH - 1));
    if (s == 0) r = d;
    else        r = (d + (longint'(1) <<< (s - 1))) >>> s;
    if (r > mx) r = mx;
    if (r < mn) r = mn;
`ifdef OUT_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[OUT_WIDTH-1:0];
  endfunction

  // Monitor: every accepted head entry is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst_in && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(out_data), 64'(-999999));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_x", out_x, e.x);
        check("out_y", out_y, e.y);
        check("out_ch", out_ch, e.ch);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint d, input int x, input int y, input int ch,
                      input bit expect_out);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d[ACC_WIDTH-1:0];
    in_x     = x[X_WIDTH-1:0];
    in_y     = y[Y_WIDTH-1:0];
    in_ch    = ch[CH_WIDTH-1:0];
    if (expect_out) begin
      e.d  = model(d, int'(shift));
      e.x  = x[X_WIDTH-1:0];
      e.y  = y[Y_WIDTH-1:0];
      e.ch = ch[CH_WIDTH-1:0];
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && fifo_count == '0) break;
      tick();
    end
    check({tag, "_sb_empty"}, 64'(sb.size()), 0);
    check({tag, "_count"}, fifo_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int maxc;
    rst_in = 1'b1; shift = '0; in_valid = 1'b0; in_data = '0;
    in_x = '0; in_y = '0; in_ch = '0; out_ready = 1'b0; clear_overflow = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_ch", out_ch, 0);
    rst_in = 1'b0;
    tick();

    // Rounding
    out_ready = 1'b1;
    shift = 5'd4; tick();
    send(24, 1, 2, 3, 1);
    send(23, 4, 5, 6, 1);
    send(-24, 1023, 1023, 63, 1);
    drain("round4");
    shift = 5'd0; tick();
    send(-5, 7, 8, 9, 1);
    drain("round0");

    // Saturation
    send(40000, 10, 11, 12, 1);
    send(-40000, 13, 14, 15, 1);
    drain("sat0");
    shift = 5'd8; tick();
    send(longint'(32'h7FFFFFFF), 16, 17, 18, 1);
    send(-longint'(64'h80000000), 19, 20, 21, 1);
    drain("sat8");
    shift = 5'd0; tick();

    // Latency: single strobe, out_valid high exactly one cycle two edges later
    send(100, 30, 31, 32, 1);
    check("lat_edge1_valid", out_valid, 0);
    tick();
    check("lat_edge2_valid", out_valid, 1);
    tick();
    check("lat_edge3_valid", out_valid, 0);
    drain("lat");

    // Throughput: back-to-back with the consumer always ready
    maxc = 0;
    for (int i = 0; i < 20; i++) begin
      send(1000 + i, i, 2 * i, i % 64, 1);
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end
    drain("tput");
    check("tput_maxcount_le2", 64'(maxc <= 2), 1);
    check("tput_overflow", overflow, 0);

    // Overflow: 10 inputs into an 8-deep FIFO, last two dropped
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(i, 100 + i, 200 + i, i, i < 8);
    tick();
    check("ovf_count", fifo_count, 8);
    check("ovf_flag", overflow, 1);
    drain("ovf");
    check("ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Push and pop while full
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(2000 + i, 300 + i, i, i, 1);
    check("full_count", fifo_count, 8);
    check("full_overflow", overflow, 0);
    out_ready = 1'b1;
    for (int i = 9; i < 19; i++) begin
      send(2000 + i, 300 + i, i, i, 1);
      check("full_pp_count", fifo_count, 8);
    end
    tick();
    check("full_pp_count_last", fifo_count, 8);
    drain("full_pp");
    check("full_pp_overflow", overflow, 0);

    // Reset mid-operation: buffered and in-flight entries are discarded
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(3000 + i, 400 + i, i, i, 0);
    check("midrst_pre_count", fifo_count, 5);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_out_data", out_data, 0);
    tick(); tick();
    check("midrst_inflight_gone", out_valid, 0);
    out_ready = 1'b1;
    send(-77, 5, 6, 7, 1);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_requant_fifo.md
Name: output_requant_fifo

Overview:
- Downstream stage of the convolution datapath. Consumes each finished accumulator value plus its (x, y, ch) coordinate as emitted by the MAC/controller output port.
- Rescales each value by a configurable arithmetic right shift with round-half-up, then saturates it to the IO data width.
- Buffers results in a small show-ahead FIFO drained by a valid/ready handshake toward the host/testbench.
- Reports overflow when results arrive faster than they are drained.

Parameters:
- ACC_WIDTH, 32, width of incoming signed accumulator value
- OUT_WIDTH, 16, width of signed output sample
- X_WIDTH, 10, width of x coordinate
- Y_WIDTH, 10, width of y coordinate
- CH_WIDTH, 6, width of output channel index
- SHIFT_WIDTH, 5, width of shift config
- FIFO_DEPTH, 8, FIFO entries; power of two, >=2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_in  in  1  synchronous reset, active-high
- shift  in  SHIFT_WIDTH  right-shift amount, 0..ACC_WIDTH-1; static while running
- in_valid  in  1  one-cycle strobe, accumulator result present; no back-pressure
- in_data  in  ACC_WIDTH  signed accumulator value
- in_x  in  X_WIDTH  output x
- in_y  in  Y_WIDTH  output y
- in_ch  in  CH_WIDTH  output channel
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head entry
- out_data  out  OUT_WIDTH  signed requantized sample at FIFO head
- out_x  out  X_WIDTH  head x
- out_y  out  Y_WIDTH  head y
- out_ch  out  CH_WIDTH  head channel
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky; a result was dropped
- clear_overflow  in  1  clears overflow

Behaviour:
- Reset (rst_in=1 at edge):
  - Outputs: out_valid=0, fifo_count=0, overflow=0; out_data/out_x/out_y/out_ch=0.
  - Internal: stage register valid=0, FIFO pointers=0.
  - Reset mid-operation discards all buffered and in-flight entries. rst_in has priority over every other input.
- Stage 1 register, loaded when in_valid=1:
  - shift=0: r = in_data.
  - shift>0: r = (in_data + 2^(shift-1)) >>> shift, computed in ACC_WIDTH+1 bits so the rounding add cannot wrap.
  - Saturation: r > 2^(OUT_WIDTH-1)-1 gives 0x7FFF; r < -2^(OUT_WIDTH-1) gives 0x8000 (values for OUT_WIDTH=16).
  - Coordinates are carried through unchanged.
- Stage 2, FIFO push: on the cycle after capture, the stage register is pushed if the stage is valid.
- Latency: in_valid at edge N gives out_valid=1 after edge N+2 when the FIFO was empty. Back-to-back in_valid sustains one result per cycle.
- FIFO:
  - Show-ahead: the head entry is visible on the out_* ports whenever out_valid=1.
  - A pop occurs when out_valid && out_ready.
  - out_ready while empty is ignored.
- Full:
  - Push with count==FIFO_DEPTH and no pop in the same cycle: the entry is dropped, overflow is set, and the FIFO contents are untouched.
  - Push and pop in the same cycle while full: both occur, count stays FIFO_DEPTH, no overflow.
- Simultaneous push and pop at any occupancy: count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Cleared by clear_overflow=1.
  - If a drop and clear_overflow=1 occur in the same cycle, set wins (overflow=1).
- Order is preserved: output order equals in_valid order.
- shift >= ACC_WIDTH is undefined; the bench must not drive it.

Optional Feature:
- Macro: OUT_RELU_EN.
- Defined: after saturation, any negative result becomes 0 (ReLU fused into requantization). Applies before the FIFO push; latency is unchanged.
- Undefined: signed saturated result is passed through unchanged.

Test Plan:
- Rounding: shift=4, in_data=24 -> out_data=2; in_data=23 -> 1; in_data=-24 -> -1; shift=0, in_data=-5 -> -5. Coordinates echoed unchanged.
- Saturation: shift=0, in_data=40000 -> 32767; in_data=-40000 -> -32768; shift=8, in_data=0x7FFFFFFF -> 32767 with no wrap. With OUT_RELU_EN, -40000 -> 0.
- Latency/throughput:
  - Single in_valid at cycle 10 with out_ready=1 -> out_valid first high at cycle 12, for one cycle.
  - 20 back-to-back inputs with out_ready=1 -> 20 outputs in order, fifo_count<=2, overflow=0.
- Full/overflow:
  - out_ready=0, 10 inputs (values 0..9), FIFO_DEPTH=8 -> fifo_count=8, overflow=1.
  - Drain then yields values 0..7.
  - clear_overflow pulse -> overflow=0.
- Push and pop while full: fill to 8, then in_valid every cycle with out_ready=1 -> count stays 8, overflow stays 0, order preserved.
- Reset mid-operation: fifo_count=5 and stage register valid, assert rst_in for one cycle -> next cycle out_valid=0, fifo_count=0, overflow=0. The in-flight value never appears.
